// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch front end: PC, imem request, instruction buffer, redirect
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned-redirect fault).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   imem_req / imem_addr   fetch request and address (address is pc_q)
//   imem_rdata             instruction word, one cycle after an accepted request
//   redirect_valid/_pc     taken branch/jump; flushes and restarts fetch
//   id_valid / id_ready    decode handshake
//   id_inst / id_pc        FIFO head (NOP and pc_q when empty)
//   id_pc4                 id_pc + 4
//   fetch_fault            sticky misaligned-redirect flag

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        fetch_fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      r_pc;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [31:0]      r_mem_inst [DEPTH];
    logic [31:0]      r_mem_pc   [DEPTH];

    logic             w_fault;
    logic [31:0]      w_target;
    logic             w_nonempty;
    logic             w_pop;
    logic             w_push;
    logic [CNT_W:0]   w_credit;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    // A misaligned target still loads pc_q as given; fetch stays parked by the fault.
    assign w_target = redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_fault <= 1'b1;
        end
    end

    assign w_fault = r_fault;
`else
    assign w_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_fault  = 1'b0;
`endif

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_nonempty = (r_count != '0);
    assign id_valid   = w_nonempty && !redirect_valid;
    assign w_pop      = id_valid && id_ready;
    assign w_push     = r_inflight && !redirect_valid;

    // Entries already owed to the FIFO (buffered plus in flight) after this
    // cycle's pop; a new request is allowed only if it still has a slot.
    assign w_credit = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight}
                    - {{CNT_W{1'b0}}, w_pop};
    assign imem_req = rst_n && !redirect_valid && !w_fault
                    && (w_credit < (CNT_W + 1)'(DEPTH));

    assign imem_addr   = r_pc;
    assign id_inst     = w_nonempty ? r_mem_inst[r_rd_ptr] : NOP;
    assign id_pc       = w_nonempty ? r_mem_pc[r_rd_ptr]   : r_pc;
    assign id_pc4      = id_pc + 32'd4;
    assign fetch_fault = w_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect_valid) begin
            r_pc       <= w_target;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight_pc <= r_pc;
            end
            if (w_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

endmodule
